// File: rtl/memory_read_controller.sv
// Read controller: accepts a one-word read request, handshakes with memory
// and captures the returned word into the MDR, with a timeout error.
module memory_read_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  ClockInput,
    input  logic                  Reset,
    input  logic                  ReadRequest,
    input  logic [ADDR_WIDTH-1:0] ReadAddress,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemRead,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] MemData
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    always_ff @(posedge ClockInput or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            count      <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
            MemRead    <= 1'b0;
            MemAddress <= '0;
            ReadData   <= '0;
        end else begin
            Done  <= 1'b0;
            Error <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ReadRequest) begin
                        MemAddress <= ReadAddress;
                        MemRead    <= 1'b1;
                        Busy       <= 1'b1;
                        count      <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ready takes priority over a timeout on the same edge.
                    if (MemReady) begin
                        ReadData <= MemData;
                        Done     <= 1'b1;
                        MemRead  <= 1'b0;
                        Busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (count == LAST) begin
                        Error   <= 1'b1;
                        MemRead <= 1'b0;
                        Busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_read_controller.sv
// Self-checking bench for memory_read_controller: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_memory_read_controller;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [AW-1:0] raddr;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] maddr;
    logic          mread;
    logic          mready;
    logic [DW-1:0] mdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a transaction is either outstanding or not; its
    // outcome is decided by first ready edge or elapsed time since acceptance.
    bit            m_busy;
    int            m_start;
    int            cyc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_done;
    bit            m_err;

    memory_read_controller #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .ClockInput (clk),
        .Reset      (rst),
        .ReadRequest(req),
        .ReadAddress(raddr),
        .Busy       (busy),
        .Done       (done),
        .Error      (err),
        .ReadData   (rdata),
        .MemAddress (maddr),
        .MemRead    (mread),
        .MemReady   (mready),
        .MemData    (mdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("busy", 32'(busy), 32'(m_busy));
        check("mread", 32'(mread), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(err), 32'(m_err));
        check("rdata", 32'(rdata), 32'(m_data));
        check("maddr", 32'(maddr), 32'(m_addr));
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_start = 0;
        m_addr  = '0;
        m_data  = '0;
        m_done  = 0;
        m_err   = 0;
    endtask

    // Drive inputs, clock one edge, advance the model and compare.
    task automatic apply(input bit r, input logic [AW-1:0] a,
                         input bit rdy, input logic [DW-1:0] d);
        req    = r;
        raddr  = a;
        mready = rdy;
        mdata  = d;
        @(posedge clk);
        #1;
        cyc++;
        m_done = 0;
        m_err  = 0;
        if (!m_busy) begin
            if (r) begin
                m_busy  = 1;
                m_addr  = a;
                m_start = cyc;
            end
        end else if (rdy) begin
            m_data = d;
            m_done = 1;
            m_busy = 0;
        end else if (cyc - m_start == TO) begin
            m_err  = 1;
            m_busy = 0;
        end
        check_all();
    endtask

    // Asynchronous reset asserted and released away from clock edges.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(err), 32'd0);
        check("rst_mread", 32'(mread), 32'd0);
        check("rst_maddr", 32'(maddr), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        req    = 1'b0;
        mready = 1'b0;
        model_reset();
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 1'b0;
        raddr  = '0;
        mready = 1'b0;
        mdata  = '0;
        cyc    = 0;
        model_reset();
        #1;
        check("init_busy", 32'(busy), 32'd0);
        check("init_rdata", 32'(rdata), 32'd0);
        check("init_maddr", 32'(maddr), 32'd0);
        #2;
        rst = 1'b0;

        // Reset mid-WAIT with BEEF already captured.
        apply(1, 16'h0010, 0, 16'h0);
        apply(0, 16'h0, 1, 16'hBEEF);
        apply(1, 16'h0020, 0, 16'h0);
        apply(0, 16'h0, 0, 16'h0);
        pulse_reset();
        for (int i = 0; i < 3; i++) apply(0, 16'h0, 1, 16'h5555);

        // Zero-wait read.
        apply(1, 16'h0040, 0, 16'h0);
        apply(0, 16'h0, 1, 16'h1234);
        apply(0, 16'h0, 0, 16'h0);

        // Three wait states.
        apply(1, 16'h0041, 0, 16'h0);
        for (int i = 0; i < 3; i++) apply(0, 16'h0, 0, 16'hFFFF);
        apply(0, 16'h0, 1, 16'hA5A5);
        apply(0, 16'h0, 0, 16'h0);

        // Timeout, prior ReadData 1234.
        apply(1, 16'h0040, 0, 16'h0);
        apply(0, 16'h0, 1, 16'h1234);
        apply(1, 16'h0042, 0, 16'h0);
        for (int i = 0; i < TO; i++) apply(0, 16'h0, 0, 16'h9999);
        apply(0, 16'h0, 0, 16'h0);

        // Ready on the final WAIT edge.
        apply(1, 16'h0043, 0, 16'h0);
        for (int i = 0; i < TO - 1; i++) apply(0, 16'h0, 0, 16'h0);
        apply(0, 16'h0, 1, 16'h00FF);
        apply(0, 16'h0, 0, 16'h0);

        // Back-to-back with request held high.
        for (int i = 0; i < 8; i++)
            apply(1, (i % 2 == 0) ? 16'h0001 : 16'h0002, 1,
                  16'(16'h7000 + i));
        apply(0, 16'h0, 0, 16'h0);

        // Randomized traffic in phases of varying memory responsiveness.
        for (int p = 0; p < 40; p++) begin
            int pct;
            pct = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(10, 70);
            if (p == 20) pulse_reset();
            for (int i = 0; i < 60; i++)
                apply($urandom_range(0, 1) == 1, 16'($urandom),
                      $urandom_range(0, 99) < pct, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_read_controller.md
# memory_read_controller

Read-side companion to the datapath's clocked 16-bit registers: accepts a one-word read request from the control unit, runs a ready-handshake with data memory, and captures the returned word into its own memory-data register (MDR). It sits between the control FSM and the memory port, and flags a timeout error if memory never answers.

## Interface
- DATA_WIDTH, 16, width of memory word and ReadData
- ADDR_WIDTH, 16, width of memory address
- TIMEOUT, 15, maximum WAIT cycles before error (legal range 1..255)

- ClockInput  input  1  single clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state immediately
- ReadRequest  input  1  start a read; sampled only in IDLE
- ReadAddress  input  ADDR_WIDTH  address to read, sampled with ReadRequest
- Busy  output  1  high while a transaction is in WAIT
- Done  output  1  one-cycle pulse: ReadData holds the new word
- Error  output  1  one-cycle pulse: timeout, ReadData unchanged
- ReadData  output  DATA_WIDTH  MDR contents; holds value between reads
- MemAddress  output  ADDR_WIDTH  registered address to memory
- MemRead  output  1  read strobe to memory, high throughout WAIT
- MemReady  input  1  memory asserts when MemData is valid
- MemData  input  DATA_WIDTH  read data from memory

## Operation
- Reset (async, any time): state IDLE; Busy=0, Done=0, Error=0, MemRead=0, MemAddress=0, ReadData=0, wait counter=0. Reset mid-WAIT aborts with no Done/Error.
- States: IDLE, WAIT. All outputs registered.
- IDLE: Busy=0, MemRead=0. At edge with ReadRequest=1: MemAddress<=ReadAddress, MemRead<=1, Busy<=1, counter<=0, go WAIT. ReadRequest=0: stay.
- WAIT, edge with MemReady=1: ReadData<=MemData, Done<=1, MemRead<=0, Busy<=0, go IDLE.
- WAIT, edge with MemReady=0 and counter==TIMEOUT-1: Error<=1, MemRead<=0, Busy<=0, go IDLE; ReadData untouched.
- WAIT, edge with MemReady=0 otherwise: counter<=counter+1, stay.
- MemReady and timeout on same edge: ready wins (Done, data captured, no Error).
- Done and Error are never high together; each high for exactly one cycle, cleared at next edge.
- ReadRequest while Busy=1 is ignored (not queued). MemReady while in IDLE is ignored.
- MemAddress holds last address after completion; only updated on accepted request.
- Counter width: smallest holding TIMEOUT-1; no wrap possible.

## Timing
- Request accepted at edge E0; MemRead and Busy high from E0.
- MemReady first sampled at E1; if high, ReadData valid and Done=1 after E1 (minimum latency 2 edges request-to-Done).
- WAIT lasts at most TIMEOUT cycles; with no ready, Error=1 after edge E(TIMEOUT).
- Back-to-back: FSM is in IDLE during the Done/Error cycle, so a ReadRequest sampled on that cycle's closing edge is accepted (one transaction per 2 cycles max throughput).
- Memory must hold MemData valid while MemReady is high; sampling is on the rising edge only.

## Test plan
- Reset: assert Reset mid-cycle with ReadData=16'hBEEF in WAIT -> all outputs 0 immediately, no Done/Error pulse after release.
- Zero-wait read: request addr 16'h0040, MemReady=1 with MemData=16'h1234 at next edge -> Done pulse one cycle, ReadData=16'h1234, MemAddress=16'h0040, Busy high exactly 1 cycle.
- Wait states: MemReady held low 3 cycles then high with 16'hA5A5 -> Busy 4 cycles, Done once, ReadData=16'hA5A5, no Error.
- Timeout: TIMEOUT=15, MemReady never high, prior ReadData=16'h1234 -> Error pulse after edge 15, ReadData still 16'h1234, MemRead low after.
- Ready on final cycle: MemReady rises on the 15th WAIT edge with 16'h00FF -> Done, ReadData=16'h00FF, Error stays 0.
- Back-to-back and ignored requests: hold ReadRequest high continuously with addresses 16'h0001 then 16'h0002, MemReady always 1 -> Done every 2nd cycle, MemAddress changes only on accepted edges, mid-WAIT address changes ignored.
